// File: rtl/iob_eth_tx_sched_pkg.sv
// iob_eth_tx_sched_pkg: shared state encoding, defaults and length check for the TX scheduler
package iob_eth_tx_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_GAP} state_t;
  localparam int NB_W        = 11;
  localparam int FRAMES_W    = 16;
  localparam int IFG_DEF     = 24;
  localparam int MIN_NB_DEF  = 9;
  localparam int MAX_NB_DEF  = 2047;
  function automatic logic len_ok(input logic [NB_W-1:0] n, input int mn, input int mx);
    return int'(n) >= mn && int'(n) <= mx;
  endfunction
endpackage

// File: rtl/iob_eth_tx_sched_if.sv
// iob_eth_tx_sched_if: scheduler-to-transmitter send/ready handshake and descriptor
interface iob_eth_tx_sched_if #(parameter int SEL_W = 1);
  logic             tx_send;
  logic             tx_ready;
  logic [10:0]      tx_nbytes;
  logic             tx_crc_en;
  logic [SEL_W-1:0] tx_sel;
  modport master (output tx_send, tx_nbytes, tx_crc_en, tx_sel, input tx_ready);
  modport slave  (input tx_send, tx_nbytes, tx_crc_en, tx_sel, output tx_ready);
endinterface

// File: rtl/iob_eth_tx_sched_rr_arb.sv
// iob_eth_rr_arb: combinational round-robin grant searching upward from last_i+1 with wrap
module iob_eth_rr_arb #(
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] last_i,
  output logic [N-1:0]     gnt_oh_o,
  output logic [SEL_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);
  logic [SEL_W-1:0] k;
  // first requester after the previous winner takes the grant
  always_comb begin
    k         = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int i = 1; i <= N; i++) begin
      k = SEL_W'((int'(last_i) + i) % N);
      if (!gnt_vld_o && req_i[k]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = k;
      end
    end
    gnt_oh_o = gnt_vld_o ? N'(1) << gnt_idx_o : '0;
  end
endmodule

// File: rtl/iob_eth_tx_sched.sv
// iob_eth_tx_sched: round-robin frame scheduler driving the MII transmitter handshake
module iob_eth_tx_sched
  import iob_eth_tx_sched_pkg::*;
#(
  parameter int              NREQ       = 2,
  parameter int              SEL_W      = 1,
  parameter int              IFG_CYCLES = IFG_DEF,
  parameter int              MIN_NBYTES = MIN_NB_DEF,
  parameter int              MAX_NBYTES = MAX_NB_DEF,
  parameter logic [15:0]     FRAMES_RST = 16'h0
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*NB_W-1:0] req_nbytes_i,
  input  logic [NREQ-1:0]      req_crc_en_i,
  output logic [NREQ-1:0]      req_ack_o,
  output logic [NREQ-1:0]      done_o,
  output logic [NREQ-1:0]      err_o,
  output logic                 busy_o,
  output logic [FRAMES_W-1:0]  frames_o,
  iob_eth_tx_sched_if.master   tx
);
  localparam int GAP_W = IFG_CYCLES > 1 ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = IFG_CYCLES == 0 ? '0 : GAP_W'(IFG_CYCLES - 1);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    last_q, last_d, sel_q, sel_d;
  logic                send_q, send_d, crc_q, crc_d, busy_q, busy_d;
  logic [NB_W-1:0]     nb_q, nb_d;
  logic [NREQ-1:0]     ack_q, ack_d, done_q, done_d, err_q, err_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [FRAMES_W-1:0] frames_q, frames_d;
  logic [NREQ-1:0]     gnt_oh;
  logic [SEL_W-1:0]    gnt_idx;
  logic                gnt_vld;
  logic [NB_W-1:0]     g_nb;
  logic                g_crc, g_ok;

  iob_eth_rr_arb #(.N(NREQ), .SEL_W(SEL_W)) u_arb (
    .req_i     (req_valid_i),
    .last_i    (last_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // winner's descriptor selected by the one-hot grant
  always_comb begin
    g_nb = '0;
    for (int r = 0; r < NREQ; r++)
      if (gnt_oh[r]) g_nb = req_nbytes_i[r*NB_W +: NB_W];
    g_crc = |(req_crc_en_i & gnt_oh);
    g_ok  = len_ok(g_nb, MIN_NBYTES, MAX_NBYTES);
  end

  // next-state and registered-output logic of the scheduler FSM
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    sel_d    = sel_q;
    send_d   = send_q;
    crc_d    = crc_q;
    nb_d     = nb_q;
    ack_d    = '0;
    done_d   = '0;
    err_d    = '0;
    gap_d    = gap_q;
    frames_d = frames_q;
    case (state_q)
      ST_IDLE: if (tx.tx_ready && gnt_vld) begin
        ack_d   = gnt_oh;
        err_d   = g_ok ? '0 : gnt_oh;
        last_d  = gnt_idx;
        sel_d   = gnt_idx;
        nb_d    = g_nb;
        crc_d   = g_crc;
        send_d  = g_ok;
        state_d = g_ok ? ST_SEND : ST_IDLE;
      end
      ST_SEND: if (!tx.tx_ready) begin
        send_d  = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: if (tx.tx_ready) begin
        done_d   = NREQ'(1) << sel_q;
        frames_d = frames_q + 16'd1;
        gap_d    = GAP_LOAD;
        state_d  = IFG_CYCLES == 0 ? ST_IDLE : ST_GAP;
      end
      default: begin
        gap_d   = gap_q - GAP_W'(1);
        state_d = gap_q == '0 ? ST_IDLE : ST_GAP;
      end
    endcase
    busy_d = state_d != ST_IDLE;
  end

  // state and output registers, cleared immediately by the shared async reset
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      state_q  <= ST_IDLE;
      last_q   <= SEL_W'(NREQ - 1);
      sel_q    <= '0;
      send_q   <= 1'b0;
      crc_q    <= 1'b0;
      busy_q   <= 1'b0;
      nb_q     <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      gap_q    <= '0;
      frames_q <= FRAMES_RST;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      send_q   <= send_d;
      crc_q    <= crc_d;
      busy_q   <= busy_d;
      nb_q     <= nb_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      gap_q    <= gap_d;
      frames_q <= frames_d;
    end

  assign req_ack_o    = ack_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;
  assign frames_o     = frames_q;
  assign tx.tx_send   = send_q;
  assign tx.tx_nbytes = nb_q;
  assign tx.tx_crc_en = crc_q;
  assign tx.tx_sel    = sel_q;
endmodule

// File: tb/tb_iob_eth_tx_sched.sv
// tb_iob_eth_tx_sched: directed self-checking bench for the TX frame scheduler
module tb_iob_eth_tx_sched;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [1:0]  req_valid, req_crc, ack, done, err;
  logic [21:0] req_nb;
  logic        busy;
  logic [15:0] frames;
  logic [1:0]  w_valid, w_ack, w_done, w_err;
  logic        w_busy;
  logic [15:0] w_frames;
  logic        tx_block;
  int          hold;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  iob_eth_tx_sched_if #(.SEL_W(1)) tx ();
  iob_eth_tx_sched_if #(.SEL_W(1)) wtx ();

  iob_eth_tx_sched #(.NREQ(2), .SEL_W(1)) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .req_valid_i  (req_valid),
    .req_nbytes_i (req_nb),
    .req_crc_en_i (req_crc),
    .req_ack_o    (ack),
    .done_o       (done),
    .err_o        (err),
    .busy_o       (busy),
    .frames_o     (frames),
    .tx           (tx)
  );

  iob_eth_tx_sched #(.NREQ(2), .SEL_W(1), .IFG_CYCLES(0), .FRAMES_RST(16'hFFFE)) dut_w (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .req_valid_i  (w_valid),
    .req_nbytes_i ({11'd64, 11'd64}),
    .req_crc_en_i (2'b00),
    .req_ack_o    (w_ack),
    .done_o       (w_done),
    .err_o        (w_err),
    .busy_o       (w_busy),
    .frames_o     (w_frames),
    .tx           (wtx)
  );

  // transmitter model: drops ready one clock after sampling send, raises it hold clocks later
  initial begin : txm
    int st, cnt;
    st = 0;
    cnt = 0;
    tx.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (!arst_n) begin
        st = 0;
        tx.tx_ready = !tx_block;
      end else case (st)
        0: begin
          tx.tx_ready = !tx_block;
          if (tx.tx_send && tx.tx_ready) st = 1;
        end
        1: begin
          tx.tx_ready = 1'b0;
          cnt = hold;
          st = 2;
        end
        default: begin
          cnt = cnt - 1;
          if (cnt == 0) begin
            tx.tx_ready = 1'b1;
            st = 0;
          end
        end
      endcase
    end
  end

  // second transmitter model for the wrap instance, fixed short frames
  initial begin : wtxm
    int st, cnt;
    st = 0;
    cnt = 0;
    wtx.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (!arst_n) begin
        st = 0;
        wtx.tx_ready = 1'b1;
      end else case (st)
        0: if (wtx.tx_send && wtx.tx_ready) st = 1;
        1: begin
          wtx.tx_ready = 1'b0;
          cnt = 2;
          st = 2;
        end
        default: begin
          cnt = cnt - 1;
          if (cnt == 0) begin
            wtx.tx_ready = 1'b1;
            st = 0;
          end
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~ack;
    w_valid   = w_valid & ~w_ack;
  endtask

  task automatic wait_ev(input string tag, input int s, input int budget, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      tick();
      n++;
      hit = s == 0 ? |ack : s == 1 ? |done : s == 2 ? |w_ack : |w_done;
    end
    if (!hit) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    logic [1:0] acc;
    req_valid = '0;
    req_crc   = '0;
    req_nb    = '0;
    w_valid   = '0;
    tx_block  = 1'b0;
    hold      = 300;
    repeat (3) tick();
    chk("rst_outs", {22'd0, ack, done, err, busy, tx.tx_send, tx.tx_crc_en, tx.tx_sel}, 32'd0);
    chk("rst_nbytes", {21'd0, tx.tx_nbytes}, 32'd0);
    chk("rst_frames", {16'd0, frames}, 32'd0);
    arst_n = 1'b1;
    repeat (2) tick();

    req_nb[10:0] = 11'd72;
    req_crc      = 2'b01;
    req_valid    = 2'b01;
    tick();
    chk("t1_ack", {30'd0, ack}, 32'd1);
    chk("t1_send", {31'd0, tx.tx_send}, 32'd1);
    chk("t1_desc", {19'd0, tx.tx_sel, tx.tx_crc_en, tx.tx_nbytes}, {19'd0, 1'b0, 1'b1, 11'd72});
    tick();
    chk("t1_send_2nd", {31'd0, tx.tx_send}, 32'd1);
    tick();
    chk("t1_send_drop", {30'd0, tx.tx_send, busy}, 32'd1);
    wait_ev("t1_done", 1, 400, n);
    chk("t1_done_lat", n, 32'd300);
    chk("t1_done", {30'd0, done}, 32'd1);
    chk("t1_frames", {16'd0, frames}, 32'd1);
    tick();
    chk("t1_done_once", {30'd0, done}, 32'd0);
    chk("t1_hold", {19'd0, tx.tx_sel, busy, tx.tx_nbytes}, {19'd0, 1'b0, 1'b1, 11'd72});
    req_valid = 2'b01;
    hold = 8;
    wait_ev("t1_ifg", 0, 60, n);
    chk("t1_ifg_lat", n, 32'd24);
    wait_ev("t1_done2", 1, 40, n);
    chk("t1_frames2", {16'd0, frames}, 32'd2);

    req_nb    = {11'd5, 11'd60};
    req_valid = 2'b11;
    wait_ev("t2_ack", 0, 60, n);
    chk("t2_ifg_lat", n, 32'd25);
    chk("t2_rej", {26'd0, ack, err, tx.tx_send, busy}, {26'd0, 2'b10, 2'b10, 1'b0, 1'b0});
    tick();
    chk("t2_next", {26'd0, ack, err, tx.tx_send, tx.tx_sel}, {26'd0, 2'b01, 2'b00, 1'b1, 1'b0});
    chk("t2_nbytes", {21'd0, tx.tx_nbytes}, 32'd60);
    wait_ev("t2_done", 1, 40, n);
    chk("t2_frames", {16'd0, frames}, 32'd3);

    tx_block     = 1'b1;
    req_nb[10:0] = 11'd100;
    req_valid    = 2'b01;
    acc = '0;
    repeat (30) begin
      tick();
      acc = acc | ack;
    end
    chk("t4_noack", {30'd0, acc}, 32'd0);
    tx_block = 1'b0;
    tick();
    chk("t4_ack", {30'd0, ack}, 32'd1);
    chk("t4_nbytes", {21'd0, tx.tx_nbytes}, 32'd100);
    repeat (2) tick();
    chk("t4_wait", {30'd0, tx.tx_send, busy}, 32'd1);

    arst_n = 1'b0;
    #1;
    chk("t5_rst_outs", {22'd0, ack, done, err, busy, tx.tx_send, tx.tx_crc_en, tx.tx_sel}, 32'd0);
    chk("t5_rst_nb_fr", {5'd0, tx.tx_nbytes, frames}, 32'd0);
    tick();
    arst_n = 1'b1;

    req_nb    = {11'd64, 11'd64};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ev("t3_ack", 0, 60, n);
      chk("t3_grant", {30'd0, ack}, k % 2 == 0 ? 32'd1 : 32'd2);
      req_valid = 2'b11;
      wait_ev("t3_done", 1, 60, n);
      chk("t3_done", {30'd0, done}, k % 2 == 0 ? 32'd1 : 32'd2);
    end
    chk("t3_frames", {16'd0, frames}, 32'd4);
    req_valid = '0;

    w_valid = 2'b01;
    wait_ev("t6_ack", 2, 20, n);
    w_valid = 2'b01;
    wait_ev("t6_done", 3, 20, n);
    chk("t6_frames_ffff", {16'd0, w_frames}, 32'hFFFF);
    wait_ev("t6_ack2", 2, 20, n);
    chk("t6_noifg_lat", n, 32'd1);
    wait_ev("t6_done2", 3, 20, n);
    chk("t6_wrap", {14'd0, w_done, w_frames}, {14'd0, 2'b01, 16'h0000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
